// File: rtl/lcd_scan_if.sv
// Signal bundle between lcd_scan and its neighbours: the snooped frame-buffer
// write port, the frame-done strobe, and the outgoing pixel stream.
interface lcd_scan_if #(
   parameter int PIX_W = 8
);
   logic             IRAM_valid;
   logic [5:0]       IRAM_A;
   logic [PIX_W-1:0] IRAM_D;
   logic             done;
   logic             pix_ready;
   logic             pix_valid;
   logic [PIX_W-1:0] pix_data;
   logic [2:0]       pix_row;
   logic [2:0]       pix_col;
   logic             row_last;
   logic             frame_last;
   logic             scan_busy;
   logic             wr_drop;

   modport master (
      output IRAM_valid, IRAM_A, IRAM_D, done, pix_ready,
      input  pix_valid, pix_data, pix_row, pix_col, row_last, frame_last,
             scan_busy, wr_drop
   );

   modport slave (
      input  IRAM_valid, IRAM_A, IRAM_D, done, pix_ready,
      output pix_valid, pix_data, pix_row, pix_col, row_last, frame_last,
             scan_busy, wr_drop
   );
endinterface

// File: rtl/lcd_scan.sv
// Snoops upstream writes into an 8x8 frame buffer and, on each rising edge of
// done, streams the frame out row-major over a valid/ready pixel interface.
//
// state | meaning
// IDLE  | buffer accepts writes, waiting for a done rising edge
// SCAN  | pixels presented one per handshake, writes are dropped
module lcd_scan #(
   parameter int PIX_W = 8,
   parameter int DIM   = 8
) (
   input  logic        clk,
   input  logic        reset,
   lcd_scan_if.slave   bus
);
   localparam int         NPIX     = DIM * DIM;
   localparam logic [5:0] LAST_IDX = 6'(NPIX - 1);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PIX_W-1:0] mem [NPIX];
   logic [5:0]       idx;
   logic [5:0]       idx_inc;
   logic [PIX_W-1:0] data_q;
   logic             done_q;
   logic             drop_q;

   logic start;
   logic hs;
   logic buf_we;
   logic drop_set;
   logic launch;
   logic advance;
   logic finish;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = bus.done & ~done_q;
      hs        = (state == SCAN) & bus.pix_ready;
      buf_we    = 1'b0;
      drop_set  = 1'b0;
      launch    = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            buf_we = bus.IRAM_valid;
            if (start) begin
               launch    = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            drop_set = bus.IRAM_valid;
            if (hs) begin
               if (idx == LAST_IDX) begin
                  finish    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign idx_inc = idx + 6'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPIX; i++) mem[i] <= '0;
         idx    <= '0;
         data_q <= '0;
         done_q <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         done_q <= bus.done;
         if (buf_we) mem[bus.IRAM_A] <= bus.IRAM_D;
         if (launch) begin
            idx    <= '0;
            // a write to address 0 on the start edge must be visible in pixel 0
            data_q <= (buf_we && bus.IRAM_A == 6'd0) ? bus.IRAM_D : mem[0];
            drop_q <= 1'b0;
         end else if (advance) begin
            idx    <= idx_inc;
            data_q <= mem[idx_inc];
         end else if (finish) begin
            idx    <= '0;
            data_q <= '0;
         end
         if (drop_set) drop_q <= 1'b1;
      end
   end

   assign bus.pix_valid  = (state == SCAN);
   assign bus.scan_busy  = (state == SCAN);
   assign bus.pix_data   = data_q;
   assign bus.pix_row    = idx[5:3];
   assign bus.pix_col    = idx[2:0];
   assign bus.row_last   = (idx[2:0] == 3'd7);
   assign bus.frame_last = (idx == LAST_IDX);
   assign bus.wr_drop    = drop_q;
endmodule

// File: tb/tb_lcd_scan.sv
// Self-checking bench for lcd_scan: a frame-snapshot reference model checked
// every cycle, directed scenarios with literal expectations, and random stress.
module tb_lcd_scan;
   logic clk = 1'b0;
   logic reset = 1'b1;

   lcd_scan_if #(.PIX_W(8)) ifc ();

   lcd_scan #(.PIX_W(8), .DIM(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is a plain array; a start copies it into a
   // frame snapshot which is then consumed one pixel per accepted handshake.
   logic [7:0] m_mem   [64];
   logic [7:0] m_frame [64];
   bit         m_busy;
   int         m_pos;
   bit         m_prev_done;
   bit         m_drop;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 64; k++) begin
            m_mem[k]   = 8'h00;
            m_frame[k] = 8'h00;
         end
         m_busy = 0; m_pos = 0; m_prev_done = 0; m_drop = 0;
      end else begin
         bit st;
         st = ifc.done && !m_prev_done;
         m_prev_done = ifc.done;
         if (!m_busy) begin
            if (ifc.IRAM_valid) m_mem[ifc.IRAM_A] = ifc.IRAM_D;
            if (st) begin
               for (int k = 0; k < 64; k++) m_frame[k] = m_mem[k];
               m_busy = 1; m_pos = 0; m_drop = 0;
            end
         end else begin
            if (ifc.IRAM_valid) m_drop = 1;
            if (ifc.pix_ready) begin
               m_pos++;
               if (m_pos == 64) begin
                  m_busy = 0;
                  m_pos  = 0;
               end
            end
         end
      end
   end

   // Accepted pixels as seen on the DUT port, for the literal checks.
   logic [7:0] obs[$];
   int         frames_seen = 0;

   always @(posedge clk) begin
      if (!reset && ifc.pix_valid && ifc.pix_ready) begin
         obs.push_back(ifc.pix_data);
         if (ifc.frame_last) frames_seen++;
      end
   end

   // Per-cycle comparison, sampled 1 ns after the active edge.
   bit         prev_v = 0;
   logic [7:0] prev_d;
   logic [2:0] prev_r, prev_c;

   always begin
      @(posedge clk);
      #1;
      check("pix_valid", ifc.pix_valid, m_busy);
      check("scan_busy", ifc.scan_busy, m_busy);
      check("wr_drop", ifc.wr_drop, m_drop);
      if (m_busy) begin
         check("pix_data", ifc.pix_data, m_frame[m_pos]);
         check("pix_row", ifc.pix_row, m_pos / 8);
         check("pix_col", ifc.pix_col, m_pos % 8);
         check("row_last", ifc.row_last, (m_pos % 8) == 7);
         check("frame_last", ifc.frame_last, m_pos == 63);
      end
      if (!reset && prev_v && !ifc.pix_ready) begin
         check("stall_data", ifc.pix_data, prev_d);
         check("stall_row", ifc.pix_row, prev_r);
         check("stall_col", ifc.pix_col, prev_c);
      end
      prev_v = !reset && ifc.pix_valid;
      prev_d = ifc.pix_data;
      prev_r = ifc.pix_row;
      prev_c = ifc.pix_col;
   end

   task automatic write_pix(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      ifc.IRAM_valid = 1'b1; ifc.IRAM_A = a; ifc.IRAM_D = d;
      @(negedge clk);
      ifc.IRAM_valid = 1'b0;
   endtask

   task automatic pulse_done();
      @(negedge clk);
      ifc.done = 1'b1;
      @(negedge clk);
      ifc.done = 1'b0;
   endtask

   task automatic wait_frames(input int target, input bit rnd_ready);
      int n = 0;
      while (frames_seen < target && n < 1000) begin
         @(negedge clk);
         ifc.pix_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
         n++;
      end
      ifc.pix_ready = 1'b1;
      if (frames_seen < target) check("frame_timeout", frames_seen, target);
      @(negedge clk);
   endtask

   task automatic count_nonzero(output int nz);
      nz = 0;
      foreach (obs[k]) if (obs[k] != 8'h00) nz++;
   endtask

   initial begin
      int f0;
      int nz;
      int n;
      ifc.IRAM_valid = 1'b0; ifc.IRAM_A = '0; ifc.IRAM_D = '0;
      ifc.done = 1'b0; ifc.pix_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", ifc.pix_valid, 0);
      check("rst_data", ifc.pix_data, 0);
      check("rst_wr_drop", ifc.wr_drop, 0);
      reset = 1'b0;

      // Ramp image, continuous ready
      for (int k = 0; k < 64; k++) write_pix(6'(k), 8'(k));
      obs.delete(); f0 = frames_seen;
      pulse_done();
      wait_frames(f0 + 1, 0);
      check("ramp_count", obs.size(), 64);
      check("ramp_px0", obs[0], 8'h00);
      check("ramp_px7", obs[7], 8'h07);
      check("ramp_px63", obs[63], 8'h3F);
      check("ramp_idle_after", ifc.pix_valid, 0);

      // Same image, random back-pressure
      obs.delete(); f0 = frames_seen;
      pulse_done();
      wait_frames(f0 + 1, 1);
      check("stall_count", obs.size(), 64);
      check("stall_px33", obs[33], 8'h21);
      check("stall_px63", obs[63], 8'h3F);

      // done held high for 200 cycles
      f0 = frames_seen;
      @(negedge clk); ifc.done = 1'b1;
      repeat (200) @(negedge clk);
      ifc.done = 1'b0;
      repeat (5) @(negedge clk);
      check("held_done_frames", frames_seen - f0, 1);

      // Write during scan is dropped
      obs.delete(); f0 = frames_seen;
      pulse_done();
      repeat (2) @(negedge clk);
      write_pix(6'd5, 8'hAA);
      check("drop_flag_set", ifc.wr_drop, 1);
      wait_frames(f0 + 1, 0);
      check("drop_px5_a", obs[5], 8'h05);
      check("drop_flag_held", ifc.wr_drop, 1);
      obs.delete(); f0 = frames_seen;
      pulse_done();
      check("drop_flag_clear", ifc.wr_drop, 0);
      wait_frames(f0 + 1, 0);
      check("drop_px5_b", obs[5], 8'h05);

      // Write and start on the same edge
      obs.delete(); f0 = frames_seen;
      @(negedge clk);
      ifc.IRAM_valid = 1'b1; ifc.IRAM_A = 6'd63; ifc.IRAM_D = 8'h7E; ifc.done = 1'b1;
      @(negedge clk);
      ifc.IRAM_valid = 1'b0; ifc.done = 1'b0;
      wait_frames(f0 + 1, 0);
      check("same_edge_px63", obs[63], 8'h7E);

      // Reset in the middle of a frame
      obs.delete(); f0 = frames_seen;
      pulse_done();
      n = 0;
      while (obs.size() < 20 && n < 100) begin @(negedge clk); n++; end
      check("reach_px20", obs.size() >= 20, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", ifc.pix_valid, 0);
      check("async_rst_busy", ifc.scan_busy, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("no_restart", ifc.pix_valid, 0);
      obs.delete(); f0 = frames_seen;
      pulse_done();
      wait_frames(f0 + 1, 0);
      count_nonzero(nz);
      check("cleared_count", obs.size(), 64);
      check("cleared_nonzero", nz, 0);

      // Random stress: writes, starts, back-pressure
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         ifc.IRAM_valid = ($urandom % 3) == 0;
         ifc.IRAM_A     = 6'($urandom % 64);
         ifc.IRAM_D     = 8'($urandom);
         if ($urandom % 30 == 0) ifc.done = ~ifc.done;
         ifc.pix_ready  = ($urandom % 4) != 0;
      end
      ifc.IRAM_valid = 1'b0; ifc.done = 1'b0; ifc.pix_ready = 1'b1;
      n = 0;
      while (ifc.scan_busy && n < 100) begin @(negedge clk); n++; end
      check("stress_drain", ifc.scan_busy, 0);

      // done already high when reset is released
      @(negedge clk); reset = 1'b1; ifc.done = 1'b1;
      @(negedge clk); reset = 1'b0; f0 = frames_seen;
      wait_frames(f0 + 1, 0);
      repeat (10) @(negedge clk);
      check("done_at_release", frames_seen - f0, 1);
      ifc.done = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
